// File: rtl/pe_net_interface.sv
// Clocked NI between a PE and the asynchronous PE port of a mesh router: 4-phase bundled-data TX/RX with an RX FIFO.
// Optional `PE_NI_ADDR_CHECK_EN`: drop packets whose dest != LOCAL_ADDR (still acked) and flag a sticky misroute_err.
module pe_net_interface #(
  parameter int         WIDTH       = 33,
  parameter logic [3:0] LOCAL_ADDR  = 4'b0101,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          tx_type,
  input  logic [3:0]                    tx_dest,
  input  logic [27:0]                   tx_payload,
  output logic                          out_req,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ack,
  input  logic                          in_req,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ack,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [WIDTH-1:0]              rx_packet,
`ifdef PE_NI_ADDR_CHECK_EN
  output logic                          misroute_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_REQ, TX_REL} tx_state_t;
  typedef enum logic {RX_WAIT_REQ, RX_WAIT_REL} rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [SYNC_STAGES-1:0] ack_sync, req_sync;
  logic ack_s, req_s;
  logic addr_ok, has_room, push, pop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_sync <= '0;
      req_sync <= '0;
    end else begin
      ack_sync <= (ack_sync << 1) | {{(SYNC_STAGES-1){1'b0}}, out_ack};
      req_sync <= (req_sync << 1) | {{(SYNC_STAGES-1){1'b0}}, in_req};
    end
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];
  assign req_s = req_sync[SYNC_STAGES-1];

  // TX: out_req is registered so the router never sees a decode glitch
  always_comb begin
    tx_next  = tx_state;
    tx_ready = rst_n && (tx_state == TX_IDLE);
    case (tx_state)
      TX_IDLE:  if (tx_valid) tx_next = TX_SETUP;
      TX_SETUP: tx_next = TX_REQ;
      TX_REQ:   if (ack_s) tx_next = TX_REL;
      TX_REL:   if (!ack_s) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      out_req  <= 1'b0;
      out_data <= '0;
    end else begin
      tx_state <= tx_next;
      out_req  <= (tx_state == TX_REQ) && !ack_s;
      if (tx_state == TX_IDLE && tx_valid)
        out_data <= WIDTH'({tx_type, tx_dest, tx_payload});
    end
  end

`ifdef PE_NI_ADDR_CHECK_EN
  assign addr_ok = (in_data[31:28] == LOCAL_ADDR);
`else
  logic unused_cfg;
  assign addr_ok    = 1'b1;
  assign unused_cfg = ^LOCAL_ADDR;
`endif

  assign has_room = (rx_count < CW'(FIFO_DEPTH));
  assign rx_valid = (rx_count != '0);
  assign pop      = rx_valid && rx_ready;
  assign in_ack   = (rx_state == RX_WAIT_REL);
  assign rx_packet = mem[rd_ptr];

  // Misrouted packets are acked regardless of room so they never wedge the router
  always_comb begin
    rx_next = rx_state;
    push    = 1'b0;
    case (rx_state)
      RX_WAIT_REQ:
        if (req_s && (has_room || !addr_ok)) begin
          rx_next = RX_WAIT_REL;
          push    = addr_ok;
        end
      RX_WAIT_REL: if (!req_s) rx_next = RX_WAIT_REQ;
      default:     rx_next = RX_WAIT_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= RX_WAIT_REQ;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      rx_state <= rx_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef PE_NI_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      misroute_err <= 1'b0;
    else if (rx_state == RX_WAIT_REQ && req_s && !addr_ok)
      misroute_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pe_net_interface.sv
// Directed bench for pe_net_interface: emulates the router side of both 4-phase handshakes.
module tb_pe_net_interface;
  localparam int WIDTH = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, tx_valid, tx_ready, tx_type, out_req, out_ack, in_req, in_ack;
  logic rx_valid, rx_ready;
  logic [3:0] tx_dest;
  logic [27:0] tx_payload;
  logic [WIDTH-1:0] out_data, in_data, rx_packet;
  logic [2:0] rx_count;
`ifdef PE_NI_ADDR_CHECK_EN
  logic misroute_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  pe_net_interface dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_type(tx_type),
    .tx_dest(tx_dest), .tx_payload(tx_payload),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_packet(rx_packet),
`ifdef PE_NI_ADDR_CHECK_EN
    .misroute_err(misroute_err),
`endif
    .rx_count(rx_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return out_req;
      1:       return in_ack;
      2:       return tx_ready;
      default: return rx_valid;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input int limit, input string tag);
    int n = 0;
    while (sig(which) !== val && n < limit) begin
      tick();
      n++;
    end
    chk(tag, 64'(sig(which)), 64'(val));
  endtask

  function automatic logic [WIDTH-1:0] rx_pk(input int i);
    return {1'b1, 4'b0101, 28'h5550000 + 28'(i)};
  endfunction

  function automatic logic [WIDTH-1:0] tx_pk(input int i);
    return {i[0], 4'(i + 3), 28'h0ABC000 + 28'(i)};
  endfunction

  task automatic rx_send(input logic [WIDTH-1:0] d, input int dly, input string tag);
    in_data = d;
    in_req  = 1'b1;
    wait_sig(1, 1'b1, 30, tag);
    repeat (dly) tick();
    in_req = 1'b0;
    wait_sig(1, 1'b0, 30, tag);
  endtask

  task automatic tx_send(input logic [WIDTH-1:0] d, input string tag);
    wait_sig(2, 1'b1, 60, tag);
    {tx_type, tx_dest, tx_payload} = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic router_tx(input logic [WIDTH-1:0] exp, input int dly, input string tag);
    wait_sig(0, 1'b1, 60, tag);
    chk(tag, 64'(out_data), 64'(exp));
    repeat (dly) tick();
    out_ack = 1'b1;
    wait_sig(0, 1'b0, 30, tag);
    out_ack = 1'b0;
  endtask

  task automatic pop(input logic [WIDTH-1:0] exp, input string tag);
    chk(tag, 64'(rx_valid), 64'd1);
    chk(tag, 64'(rx_packet), 64'(exp));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_type = 1'b0; tx_dest = '0; tx_payload = '0;
    out_ack = 1'b0; in_req = 1'b0; in_data = '0; rx_ready = 1'b0;
    tick(); tick();
    chk("rst_tx_ready", 64'(tx_ready), 64'd0);
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_in_ack", 64'(in_ack), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_rx_count", 64'(rx_count), 64'd0);
`ifdef PE_NI_ADDR_CHECK_EN
    chk("rst_misroute", 64'(misroute_err), 64'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("idle_tx_ready", 64'(tx_ready), 64'd1);

    // TX single packet, exact handshake latency
    tx_type = 1'b1; tx_dest = 4'b1001; tx_payload = 28'h2E972DC; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("tx_accept_ready", 64'(tx_ready), 64'd0);
    chk("tx_out_data", 64'(out_data), 64'h1_92E9_72DC);
    tick();
    chk("tx_req_n1", 64'(out_req), 64'd0);
    tick();
    chk("tx_req_n2", 64'(out_req), 64'd1);
    repeat (3) tick();
    chk("tx_req_held", 64'(out_req), 64'd1);
    out_ack = 1'b1;
    tick(); tick();
    chk("tx_req_before_sync", 64'(out_req), 64'd1);
    tick();
    chk("tx_req_fall", 64'(out_req), 64'd0);
    out_ack = 1'b0;
    tick(); tick();
    chk("tx_rel_ready", 64'(tx_ready), 64'd0);
    chk("tx_rel_data", 64'(out_data), 64'h1_92E9_72DC);
    tick();
    chk("tx_ready_back", 64'(tx_ready), 64'd1);

    // RX first packet latency, then fill the FIFO
    in_data = rx_pk(1); in_req = 1'b1;
    tick(); tick();
    chk("rx_ack_early", 64'(in_ack), 64'd0);
    chk("rx_valid_early", 64'(rx_valid), 64'd0);
    tick();
    chk("rx_ack_rise", 64'(in_ack), 64'd1);
    chk("rx_valid_rise", 64'(rx_valid), 64'd1);
    chk("rx_count_1", 64'(rx_count), 64'd1);
    in_req = 1'b0;
    wait_sig(1, 1'b0, 10, "rx_ack_fall");
    for (int i = 2; i <= 4; i++) rx_send(rx_pk(i), 0, "rx_fill");
    chk("rx_count_full", 64'(rx_count), 64'd4);
    in_data = rx_pk(5); in_req = 1'b1;
    repeat (6) tick();
    chk("rx_full_noack", 64'(in_ack), 64'd0);
    chk("rx_full_count", 64'(rx_count), 64'd4);
    chk("rx_full_head", 64'(rx_packet), 64'(rx_pk(1)));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_pop_count", 64'(rx_count), 64'd3);
    chk("rx_pop_noack", 64'(in_ack), 64'd0);
    tick();
    chk("rx_5th_ack", 64'(in_ack), 64'd1);
    chk("rx_5th_count", 64'(rx_count), 64'd4);
    chk("rx_5th_head", 64'(rx_packet), 64'(rx_pk(2)));
    in_req = 1'b0;
    wait_sig(1, 1'b0, 10, "rx_5th_rel");
    pop(rx_pk(2), "pop_p2");
    pop(rx_pk(3), "pop_p3");
    chk("rx_count_2", 64'(rx_count), 64'd2);

    // Simultaneous push and pop at count=2, across pointer wrap
    in_data = rx_pk(6); in_req = 1'b1;
    tick(); tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("pp_ack", 64'(in_ack), 64'd1);
    chk("pp_count", 64'(rx_count), 64'd2);
    in_req = 1'b0;
    wait_sig(1, 1'b0, 10, "pp_rel");
    pop(rx_pk(5), "pop_p5");
    pop(rx_pk(6), "pop_p6");
    chk("rx_empty_count", 64'(rx_count), 64'd0);
    chk("rx_empty_valid", 64'(rx_valid), 64'd0);

    // Reset in the middle of a TX handshake
    tx_send({1'b0, 4'hA, 28'h1234567}, "mid_accept");
    wait_sig(0, 1'b1, 10, "mid_req_up");
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req", 64'(out_req), 64'd0);
    chk("mid_rst_ready", 64'(tx_ready), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", 64'(tx_ready), 64'd1);
    fork
      tx_send({1'b1, 4'h3, 28'h0FEDCBA}, "post_rst_accept");
      router_tx(33'h1_30FE_DCBA, 2, "post_rst_tx");
    join
    wait_sig(2, 1'b1, 10, "post_rst_ready");

    // Full duplex: 10 packets each way with random router delays
    fork
      begin
        for (int i = 0; i < 10; i++) tx_send(tx_pk(i), "fd_tx_accept");
      end
      begin
        for (int i = 0; i < 10; i++) router_tx(tx_pk(i), $urandom_range(1, 5), "fd_tx_data");
      end
      begin
        for (int i = 0; i < 10; i++) begin
          rx_send(rx_pk(10 + i), $urandom_range(1, 5), "fd_rx_hs");
          repeat ($urandom_range(1, 5)) tick();
        end
      end
      begin
        for (int j = 0; j < 10; j++) begin
          wait_sig(3, 1'b1, 200, "fd_rx_valid");
          pop(rx_pk(10 + j), "fd_rx_order");
          repeat ($urandom_range(0, 3)) tick();
        end
      end
    join
    chk("fd_rx_count", 64'(rx_count), 64'd0);
    wait_sig(2, 1'b1, 20, "fd_tx_idle");

`ifdef PE_NI_ADDR_CHECK_EN
    rx_send({1'b0, 4'b0100, 28'h00000AB}, 0, "bad_dest_hs");
    chk("bad_dest_count", 64'(rx_count), 64'd0);
    chk("bad_dest_err", 64'(misroute_err), 64'd1);
    rx_send({1'b0, 4'b0101, 28'h00000CD}, 0, "good_dest_hs");
    chk("good_dest_count", 64'(rx_count), 64'd1);
    chk("err_sticky", 64'(misroute_err), 64'd1);
    pop({1'b0, 4'b0101, 28'h00000CD}, "good_dest_head");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pe_net_interface.md
# pe_net_interface

Clocked network interface between a synchronous processing element (PE) and the PE port of an asynchronous mesh router. On the transmit side it assembles 33-bit packets `{type, dest[3:0], payload[27:0]}` and pushes them into the router's PE input over a 4-phase bundled-data handshake. On the receive side it accepts packets from the router's PE output over the same handshake, buffers them in a small FIFO and presents them to the PE with valid/ready.

## Interface
Parameters:
- WIDTH, 33, packet width; bit 32 is type, [31:28] is dest, [27:0] is payload.
- LOCAL_ADDR, 4'b0101, this PE's 4-bit node address.
- FIFO_DEPTH, 4, RX buffer entries (power of 2, ≥2).
- SYNC_STAGES, 2, flip-flop synchronizer depth on incoming req/ack.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- tx_valid  in  1  PE has a packet to send.
- tx_ready  out  1  interface accepts a TX packet this cycle.
- tx_type  in  1  packet type bit.
- tx_dest  in  4  destination address.
- tx_payload  in  28  payload.
- out_req  out  1  4-phase request toward router PE input.
- out_data  out  WIDTH  bundled data toward router PE input.
- out_ack  in  1  asynchronous acknowledge from router.
- in_req  in  1  asynchronous request from router PE output.
- in_data  in  WIDTH  bundled data from router.
- in_ack  out  1  acknowledge toward router.
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  PE pops the head entry.
- rx_packet  out  WIDTH  FIFO head entry.
- rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Synchronizers: out_ack → ack_s and in_req → req_s, each through SYNC_STAGES flops. FSMs use only the synchronized versions.
- TX FSM:
  - IDLE: tx_ready=1. On tx_valid, register out_data={tx_type,tx_dest,tx_payload} and go to SETUP.
  - SETUP: one cycle with data stable and req low; go to REQ.
  - REQ: out_req=1; wait for ack_s=1, then go to REL.
  - REL: out_req=0; wait for ack_s=0, then go to IDLE.
  - out_data is held stable from SETUP until the cycle REL exits.
- RX FSM:
  - WAIT_REQ: if req_s=1 and count<FIFO_DEPTH, push in_data, set in_ack=1 and go to WAIT_REL. If the FIFO is full, stay in WAIT_REQ with in_ack=0; this back-pressures the router.
  - WAIT_REL: hold in_ack=1 until req_s=0, then clear in_ack and go to WAIT_REQ.
- FIFO:
  - Circular buffer with wrapping read/write pointers. Pop occurs when rx_valid & rx_ready.
  - Push eligibility is evaluated against count at the edge, before any same-cycle pop. A simultaneous push and pop leaves count unchanged.
  - rx_packet is the head entry; it is don't-care when rx_valid=0.

## Timing
- Reset (rst_n=0 at a clk edge): both FSMs return to IDLE/WAIT_REQ. out_req=0, in_ack=0, out_data=0, FIFO empty (rx_valid=0, rx_count=0), synchronizer flops=0, tx_ready=0 while rst_n=0.
- TX latency: acceptance at edge N, out_req rises after edge N+2. Handshake completes SYNC_STAGES+1 cycles after each router ack transition, at minimum.
- RX: in_ack rises SYNC_STAGES+1 edges after in_req rises, provided the FIFO is not full. rx_valid rises at the same edge as in_ack.
- Reset mid-handshake: state is abandoned and req/ack are driven low. The router must be reset concurrently; no packet recovery is required.
- TX accepts at most one packet per complete 4-phase cycle; there is no TX buffering beyond out_data.

## Configuration
- PE_NI_ADDR_CHECK_EN defined:
  - RX compares in_data[31:28] against LOCAL_ADDR.
  - On mismatch the packet is still acknowledged (full handshake) but not pushed. A sticky misroute_err output (1 bit, reset 0) is set.
  - A mismatched packet is acknowledged even when the FIFO is full.
- PE_NI_ADDR_CHECK_EN undefined: every received packet is pushed, and misroute_err is absent.

## Test plan
- TX single packet: tx_type=1, tx_dest=4'b1001, tx_payload=28'h2E9_72DC; emulated router acks after 3 cycles → out_data=33'h1_92E9_72DC held stable until ack_s falls; out_req rises 2 cycles after acceptance; tx_ready returns to 1 after the ack falls.
- RX fill: router sends 5 packets with dest 4'b0101 while rx_ready=0 → first 4 acked, rx_count=4, 5th in_req held without ack. Raising rx_ready for 1 cycle → 5th acked, rx_count=4, head is packet 2.
- RX simultaneous push/pop at count=2 → count stays 2, order preserved (FIFO ordering across pointer wrap after 6 total packets).
- Reset mid-TX: assert rst_n=0 while in REQ → out_req=0, tx_ready=0 next edge; after release a new packet sends normally.
- Full-duplex: TX and RX handshakes concurrent over 10 packets each with random ack delays 1–5 cycles → no loss, no reordering, payloads match.
- With PE_NI_ADDR_CHECK_EN: RX packet dest 4'b0100 → acked, rx_count unchanged, misroute_err=1. Next dest 4'b0101 packet is pushed normally.
